mem_port_arbiter: RTL and testbench

- Shares the single-ported Data_mem between two requesters: the instruction-side refill path (port I, read-only) and the dcache miss/write-back path (port D, read/write).
- Sits between the requesters and Data_mem, and drives Data_mem's rdaddress/wraddress/rden/wren/write_data.
- Serialises one transaction at a time, returns read data to the owning requester, and prevents I-side starvation under D-side priority.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/arb_pick.sv | 37 +++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the Data_mem port arbiter: FSM encoding, owner codes, default widths.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;
  localparam int WEN_W      = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_RWAIT = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and Data_mem signal bundle; slave = arbiter side, master = requesters + memory side.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic [WEN_W-1:0]  d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_rdaddr;
  logic [ADDR_W-1:0] mem_wraddr;
  logic              mem_rden;
  logic [WEN_W-1:0]  mem_wren;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_rdaddr, mem_wraddr, mem_rden, mem_wren, mem_wdata
  );
  modport master (
    output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_rdaddr, mem_wraddr, mem_rden, mem_wren, mem_wdata
  );
endinterface

// File: rtl/arb_pick.sv
// Winner select for the IDLE cycle plus the I-side starvation counter.
module arb_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle_i,
  input  logic i_req_i,
  input  logic d_req_i,
  output logic grant_o,
  output logic pick_d_o
);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve_q, starve_d;
  logic            under_limit;

  assign under_limit = (starve_q < SC_W'(STARVE_LIMIT));

  always_comb begin
    pick_d_o = d_req_i && (under_limit || !i_req_i);
    grant_o  = idle_i && (i_req_i || d_req_i);
    starve_d = starve_q;
    if (grant_o) begin
      // Only D grants that leave I waiting count toward forcing I.
      if (pick_d_o && i_req_i)
        starve_d = under_limit ? starve_q + 1'b1 : starve_q;
      else
        starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises I-side refills and D-side miss/write-back traffic onto single-ported Data_mem.
// Define ARB_PERF_CNT_EN to add grant/conflict performance counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MEM_RD_LAT   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_i_gnt,
  output logic [31:0]         perf_d_gnt,
  output logic [31:0]         perf_conflict
`endif
);
  localparam int CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WEN_W-1:0]  wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic idle, grant, pick_d, issue, is_wr, rd_done;

  assign idle    = (state_q == ST_IDLE);
  assign issue   = (state_q == ST_ISSUE);
  assign is_wr   = |wen_q;
  assign rd_done = (state_q == ST_RWAIT) && (cnt_q == '0);

  arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk      (clk),
    .rst      (rst),
    .idle_i   (idle),
    .i_req_i  (bus.i_req),
    .d_req_i  (bus.d_req),
    .grant_o  (grant),
    .pick_d_o (pick_d)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_ISSUE;
          owner_d = pick_d ? OWN_D : OWN_I;
          if (pick_d) begin
            addr_d  = bus.d_addr;
            wen_d   = bus.d_wen;
            wdata_d = bus.d_wdata;
          end else begin
            addr_d  = bus.i_addr;
            wen_d   = '0;
            wdata_d = '0;
          end
        end
      end
      ST_ISSUE: begin
        if (is_wr) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RWAIT;
          cnt_d   = CNT_W'(MEM_RD_LAT - 1);
        end
      end
      ST_RWAIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_I;
      addr_q  <= '0;
      wen_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.i_gnt = grant && !pick_d;
  assign bus.d_gnt = grant && pick_d;

  // Buses are gated to zero outside their active cycle so reset and idle leave them quiet.
  assign bus.mem_rden   = issue && !is_wr;
  assign bus.mem_rdaddr = bus.mem_rden ? addr_q : '0;
  assign bus.mem_wren   = issue ? wen_q : '0;
  assign bus.mem_wraddr = (issue && is_wr) ? addr_q : '0;
  assign bus.mem_wdata  = (issue && is_wr) ? wdata_q : '0;

  assign bus.i_rvalid = rd_done && (owner_q == OWN_I);
  assign bus.d_rvalid = rd_done && (owner_q == OWN_D);
  assign bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_i_gnt_q, perf_d_gnt_q, perf_conflict_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_i_gnt_q    <= '0;
      perf_d_gnt_q    <= '0;
      perf_conflict_q <= '0;
    end else begin
      if (bus.i_gnt) perf_i_gnt_q <= perf_i_gnt_q + 32'd1;
      if (bus.d_gnt) perf_d_gnt_q <= perf_d_gnt_q + 32'd1;
      if (idle && bus.i_req && bus.d_req) perf_conflict_q <= perf_conflict_q + 32'd1;
    end
  end

  assign perf_i_gnt    = perf_i_gnt_q;
  assign perf_d_gnt    = perf_d_gnt_q;
  assign perf_conflict = perf_conflict_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int LAT1   = 1;
  localparam int LAT3   = 3;
  localparam int STARVE = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus3 ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] p1_i, p1_d, p1_c, p3_i, p3_d, p3_c;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_RD_LAT(LAT1), .STARVE_LIMIT(STARVE)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
`ifdef ARB_PERF_CNT_EN
    , .perf_i_gnt (p1_i), .perf_d_gnt (p1_d), .perf_conflict (p1_c)
`endif
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_RD_LAT(LAT3), .STARVE_LIMIT(STARVE)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
`ifdef ARB_PERF_CNT_EN
    , .perf_i_gnt (p3_i), .perf_d_gnt (p3_d), .perf_conflict (p3_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [268:0] outs1();
    return {bus1.i_gnt, bus1.i_rvalid, bus1.i_rdata, bus1.d_gnt, bus1.d_rvalid, bus1.d_rdata,
            bus1.mem_rdaddr, bus1.mem_wraddr, bus1.mem_rden, bus1.mem_wren, bus1.mem_wdata};
  endfunction

  function automatic logic [268:0] outs3();
    return {bus3.i_gnt, bus3.i_rvalid, bus3.i_rdata, bus3.d_gnt, bus3.d_rvalid, bus3.d_rdata,
            bus3.mem_rdaddr, bus3.mem_wraddr, bus3.mem_rden, bus3.mem_wren, bus3.mem_wdata};
  endfunction

  task automatic clear_inputs();
    bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_wen = '0;
    bus1.d_addr = '0; bus1.d_wdata = '0; bus1.mem_rdata = '0;
    bus3.i_req = 0; bus3.i_addr = '0; bus3.d_req = 0; bus3.d_wen = '0;
    bus3.d_addr = '0; bus3.d_wdata = '0; bus3.mem_rdata = '0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 5) rst = 1'b1;
      bus1.mem_rdata = rand64();
      bus3.mem_rdata = rand64();
      #1;
      checks++;
      if (outs1() !== '0) begin
        errors++;
        $display("FAIL reset_idle_1 cycle %0d: outputs=%h required 0", c, outs1());
      end
      checks++;
      if (outs3() !== '0) begin
        errors++;
        $display("FAIL reset_idle_3 cycle %0d: outputs=%h required 0", c, outs3());
      end
    end
  endtask

  // Abort a LAT=3 read first in its ISSUE cycle, then in RWAIT.
  task automatic test_reset_mid();
    int rv;
    for (int abort_at = 1; abort_at <= 2; abort_at++) begin
      @(negedge clk);
      bus3.i_req = 1; bus3.i_addr = 32'h80;
      #1;
      checks++;
      if (bus3.i_gnt !== 1'b1) begin
        errors++;
        $display("FAIL abort_gnt: i_gnt=%b required 1", bus3.i_gnt);
      end
      for (int c = 1; c <= abort_at; c++) begin
        @(negedge clk);
        bus3.i_req = 0;
      end
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (outs3() !== '0) begin
        errors++;
        $display("FAIL abort_drop at=%0d: outputs=%h required 0", abort_at, outs3());
      end
      rv = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (c == 2) rst = 1'b1;
        bus3.mem_rdata = rand64();
        #1;
        if (bus3.i_rvalid === 1'b1) rv++;
      end
      checks++;
      if (rv != 0) begin
        errors++;
        $display("FAIL abort_no_rvalid at=%0d: pulses=%0d required 0", abort_at, rv);
      end
    end
  endtask

  task automatic test_d_read();
    logic [63:0] r;
    @(negedge clk);
    bus1.d_req = 1; bus1.d_wen = 8'h00; bus1.d_addr = 32'h100;
    #1;
    checks++;
    if ({bus1.d_gnt, bus1.i_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL dread_gnt: d/i gnt=%b required 10", {bus1.d_gnt, bus1.i_gnt});
    end
    @(negedge clk);
    bus1.d_req = 0;
    #1;
    checks++;
    if ({bus1.mem_rden, bus1.mem_rdaddr, bus1.mem_wren} !== {1'b1, 32'h100, 8'h00}) begin
      errors++;
      $display("FAIL dread_issue: rden=%b rdaddr=%h wren=%h required 1/100/00",
               bus1.mem_rden, bus1.mem_rdaddr, bus1.mem_wren);
    end
    @(negedge clk);
    r = rand64(); bus1.mem_rdata = r;
    #1;
    checks++;
    if ({bus1.d_rvalid, bus1.d_rdata, bus1.i_rvalid} !== {1'b1, r, 1'b0}) begin
      errors++;
      $display("FAIL dread_data: d_rvalid=%b d_rdata=%h i_rvalid=%b required 1/%h/0",
               bus1.d_rvalid, bus1.d_rdata, bus1.i_rvalid, r);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus1.d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL dread_single_pulse: d_rvalid=%b required 0", bus1.d_rvalid);
    end
  endtask

  task automatic test_d_write();
    @(negedge clk);
    bus1.d_req = 1; bus1.d_wen = 8'h0F; bus1.d_addr = 32'h208; bus1.d_wdata = 64'hDEAD_BEEF;
    #1;
    checks++;
    if (bus1.d_gnt !== 1'b1) begin
      errors++;
      $display("FAIL dwrite_gnt: d_gnt=%b required 1", bus1.d_gnt);
    end
    @(negedge clk);
    bus1.d_wen = 8'h00; bus1.d_addr = 32'h300; // held req becomes a new read request
    #1;
    checks++;
    if ({bus1.mem_wren, bus1.mem_wraddr, bus1.mem_wdata, bus1.mem_rden, bus1.d_gnt}
        !== {8'h0F, 32'h208, 64'hDEAD_BEEF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL dwrite_issue: wren=%h wraddr=%h wdata=%h rden=%b gnt=%b required 0f/208/deadbeef/0/0",
               bus1.mem_wren, bus1.mem_wraddr, bus1.mem_wdata, bus1.mem_rden, bus1.d_gnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus1.d_gnt, bus1.mem_wren, bus1.d_rvalid} !== {1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL dwrite_next_gnt: gnt=%b wren=%h rvalid=%b required 1/00/0",
               bus1.d_gnt, bus1.mem_wren, bus1.d_rvalid);
    end
    @(negedge clk);
    bus1.d_req = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [2:0] seen;
    @(negedge clk);
    bus1.d_req = 1; bus1.d_wen = 8'h00; bus1.d_addr = 32'h10;
    bus1.i_req = 1; bus1.i_addr = 32'h20;
    #1;
    checks++;
    if ({bus1.d_gnt, bus1.i_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL simul_first: d/i gnt=%b required 10", {bus1.d_gnt, bus1.i_gnt});
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus1.d_req = 0;
      #1;
      seen[c-1] = bus1.i_gnt;
    end
    checks++;
    if (seen !== 3'b100) begin
      errors++;
      $display("FAIL simul_i_follow: i_gnt at T+3..T+1=%b required 100", seen);
    end
    @(negedge clk);
    bus1.i_req = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_starvation();
    int  k;
    int  lim;
    bit  exp_d;
    k = 0; lim = 0;
    @(negedge clk);
    bus1.i_req = 1; bus1.i_addr = 32'h500;
    bus1.d_req = 1; bus1.d_wen = 8'hFF; bus1.d_addr = 32'h600; bus1.d_wdata = rand64();
    while (k < 12 && lim < 200) begin
      #1;
      if (bus1.i_gnt === 1'b1 || bus1.d_gnt === 1'b1) begin
        exp_d = (k % (STARVE + 1)) != STARVE;
        checks++;
        if ({bus1.d_gnt, bus1.i_gnt} !== {exp_d, !exp_d}) begin
          errors++;
          $display("FAIL starve_order grant %0d: d/i gnt=%b required %b",
                   k, {bus1.d_gnt, bus1.i_gnt}, {exp_d, !exp_d});
        end
        k++;
      end
      @(negedge clk);
      lim++;
    end
    bus1.i_req = 0; bus1.d_req = 0;
    checks++;
    if (k < 12) begin
      errors++;
      $display("FAIL starve_timeout: grants=%0d required 12", k);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_lat3();
    int          got;
    int          pulses;
    logic [63:0] r;
    got = -1; pulses = 0;
    @(negedge clk);
    bus3.i_req = 1; bus3.i_addr = 32'h40;
    #1;
    checks++;
    if (bus3.i_gnt !== 1'b1) begin
      errors++;
      $display("FAIL lat3_gnt: i_gnt=%b required 1", bus3.i_gnt);
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus3.i_req = 0;
      r = rand64(); bus3.mem_rdata = r;
      #1;
      if (bus3.i_rvalid === 1'b1) begin
        pulses++;
        if (got < 0) begin
          got = c;
          checks++;
          if (bus3.i_rdata !== r) begin
            errors++;
            $display("FAIL lat3_data: i_rdata=%h required %h", bus3.i_rdata, r);
          end
        end
      end
      if (bus3.d_rvalid === 1'b1) pulses += 100;
    end
    checks++;
    if (got != 1 + LAT3 || pulses != 1) begin
      errors++;
      $display("FAIL lat3_latency: first rvalid at %0d pulses=%0d required %0d/1", got, pulses, 1 + LAT3);
    end
`ifdef ARB_PERF_CNT_EN
    checks++;
    if ({p3_i, p3_d, p3_c} !== {32'd1, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL lat3_perf: i=%0d d=%0d conflict=%0d required 1/0/0", p3_i, p3_d, p3_c);
    end
`endif
  endtask

  // Model: one transaction at a time; each grant occupies the port for 2 cycles (write)
  // or 2+LAT cycles (read), with strobes at grant+1 and read data at grant+1+LAT.
  task automatic test_random();
    int          busy_until, starve, g_cycle, win;
    int          n_i, n_d, n_conf;
    bit          i_hold, d_hold, g_d, g_write, idle_m, exp_iv, exp_dv;
    logic [31:0] g_addr;
    logic [7:0]  g_wen;
    logic [63:0] g_wdata, rd;
    logic [136:0] exp_mem, got_mem;
    @(negedge clk);
    rst = 1'b0; clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    busy_until = 0; starve = 0; g_cycle = -100; n_i = 0; n_d = 0; n_conf = 0;
    i_hold = 0; d_hold = 0; g_d = 0; g_write = 0; g_addr = '0; g_wen = '0; g_wdata = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!i_hold) begin
        bus1.i_req = 0;
        if ($urandom_range(0, 99) < 40) begin
          i_hold = 1; bus1.i_req = 1; bus1.i_addr = $urandom;
        end
      end
      if (!d_hold) begin
        bus1.d_req = 0;
        if ($urandom_range(0, 99) < 45) begin
          d_hold = 1; bus1.d_req = 1; bus1.d_addr = $urandom; bus1.d_wdata = rand64();
          bus1.d_wen = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
        end
      end
      rd = rand64(); bus1.mem_rdata = rd;
      #1;
      idle_m = (c >= busy_until);
      win = 0;
      if (idle_m) begin
        if (d_hold && starve < STARVE) win = 2;
        else if (i_hold)               win = 1;
        else if (d_hold)               win = 2;
      end
      if (idle_m && i_hold && d_hold) n_conf++;
      exp_mem = '0;
      if (c == g_cycle + 1)
        exp_mem = g_write ? {1'b0, 32'h0, g_wen, g_addr, g_wdata} : {1'b1, g_addr, 8'h0, 32'h0, 64'h0};
      exp_iv = !g_write && !g_d && (c == g_cycle + 1 + LAT1);
      exp_dv = !g_write &&  g_d && (c == g_cycle + 1 + LAT1);
      got_mem = {bus1.mem_rden, bus1.mem_rdaddr, bus1.mem_wren, bus1.mem_wraddr, bus1.mem_wdata};

      checks++;
      if ({bus1.i_gnt, bus1.d_gnt} !== {win == 1, win == 2}) begin
        errors++;
        $display("FAIL rand_gnt cycle %0d: i/d gnt=%b required %b", c,
                 {bus1.i_gnt, bus1.d_gnt}, {win == 1, win == 2});
      end
      checks++;
      if ({bus1.i_rvalid, bus1.d_rvalid} !== {exp_iv, exp_dv}) begin
        errors++;
        $display("FAIL rand_rvalid cycle %0d: i/d rvalid=%b required %b", c,
                 {bus1.i_rvalid, bus1.d_rvalid}, {exp_iv, exp_dv});
      end
      checks++;
      if ({bus1.i_rdata, bus1.d_rdata} !== {exp_iv ? rd : 64'h0, exp_dv ? rd : 64'h0}) begin
        errors++;
        $display("FAIL rand_rdata cycle %0d: i=%h d=%h required i=%h d=%h", c, bus1.i_rdata,
                 bus1.d_rdata, exp_iv ? rd : 64'h0, exp_dv ? rd : 64'h0);
      end
      checks++;
      if (got_mem !== exp_mem) begin
        errors++;
        $display("FAIL rand_mem cycle %0d: rden/rdaddr/wren/wraddr/wdata=%h required %h", c, got_mem, exp_mem);
      end
      checks++;
      if (bus1.mem_rden === 1'b1 && bus1.mem_wren !== 8'h00) begin
        errors++;
        $display("FAIL rand_excl cycle %0d: rden=1 wren=%h required rden and wren exclusive", c, bus1.mem_wren);
      end

      if (win != 0) begin
        g_cycle = c;
        g_d     = (win == 2);
        g_write = g_d && (bus1.d_wen != 8'h00);
        g_addr  = g_d ? bus1.d_addr : bus1.i_addr;
        g_wen   = g_d ? bus1.d_wen : 8'h00;
        g_wdata = g_d ? bus1.d_wdata : 64'h0;
        busy_until = c + (g_write ? 2 : 2 + LAT1);
        if (g_d) begin
          n_d++;
          starve = i_hold ? ((starve < STARVE) ? starve + 1 : STARVE) : 0;
          d_hold = 0;
        end else begin
          n_i++;
          starve = 0;
          i_hold = 0;
        end
      end
    end
`ifdef ARB_PERF_CNT_EN
    checks++;
    if ({p1_i, p1_d, p1_c} !== {32'(n_i), 32'(n_d), 32'(n_conf)}) begin
      errors++;
      $display("FAIL rand_perf: i=%0d d=%0d conflict=%0d required %0d/%0d/%0d",
               p1_i, p1_d, p1_c, n_i, n_d, n_conf);
    end
`endif
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_reset_mid();
    test_d_read();
    test_d_write();
    test_simultaneous();
    test_starvation();
    test_lat3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
